// File: rtl/vending_controller_param.sv
// vending_controller_param
//
// Parametrised vending controller. It sits between the coin-acceptor front end and the
// dispenser / change-hopper drivers. Each product has its own price. The controller keeps a
// credit accumulator that is capped at MAX_CREDIT; a coin that would push credit past the cap
// is rejected. Selection and cancel are explicit inputs. Change is paid out serially, one
// coin per cycle, Rs10 first and then Rs5.
//
// All prices and credit values are in units of Rs 5.
//
// Parameters:
//   CREDIT_W   - width of the credit register and of each price entry
//   NUM_PROD   - number of products (must be >= 2)
//   PRICES     - packed price table; entry i sits at [i*CREDIT_W +: CREDIT_W]
//   MAX_CREDIT - largest credit held (must be < 2**CREDIT_W)
//
// Ports:
//   clk               in   system clock, rising edge
//   rst               in   asynchronous active-low reset
//   coin_valid        in   one-cycle coin strobe
//   coin              in   coin code: 01 Rs5, 10 Rs10, 11 Rs20, 00 invalid
//   sel_valid         in   one-cycle product request
//   sel_id            in   requested product index
//   cancel            in   refund request
//   coin_accept       out  pulse: coin added to credit
//   coin_reject       out  pulse: coin returned to the customer
//   product_dispensed out  pulse: product released
//   product_id        out  index of the last dispensed product (held between vends)
//   sel_error         out  pulse: invalid selection or insufficient credit
//   change_valid      out  pulse: one change coin is output
//   change_coin       out  01 Rs5, 10 Rs10, 00 when change_valid is low
//   credit            out  current credit
//   busy              out  high while change is being returned
//
// Every output comes straight from a flop. Inputs sampled at edge k are answered in
// cycle k+1.

module vending_controller_param #(
  parameter int unsigned                   CREDIT_W   = 6,
  parameter int unsigned                   NUM_PROD   = 4,
  parameter logic [NUM_PROD*CREDIT_W-1:0]  PRICES     = {6'd4, 6'd3, 6'd2, 6'd1},
  parameter int unsigned                   MAX_CREDIT = 8,
  localparam int unsigned                  ID_W       = $clog2(NUM_PROD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                product_dispensed,
  output logic [ID_W-1:0]     product_id,
  output logic                sel_error,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StCredit, StChange} state_e;

  localparam logic [1:0] CoinRs5  = 2'b01;
  localparam logic [1:0] CoinRs10 = 2'b10;
  localparam logic [1:0] CoinRs20 = 2'b11;

  state_e state_q, state_d;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [ID_W-1:0]     product_id_q, product_id_d;
  logic [1:0]          change_coin_q, change_coin_d;
  logic                coin_accept_q, coin_accept_d;
  logic                coin_reject_q, coin_reject_d;
  logic                product_dispensed_q, product_dispensed_d;
  logic                sel_error_q, sel_error_d;
  logic                change_valid_q, change_valid_d;

  // ---------------------------------------------------------------------------
  // Shared datapath decode
  // ---------------------------------------------------------------------------

  logic [CREDIT_W-1:0] coin_val;
  logic                coin_nonzero;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;

  always_comb begin
    coin_val = '0;
    case (coin)
      CoinRs5:  coin_val = CREDIT_W'(1);
      CoinRs10: coin_val = CREDIT_W'(2);
      CoinRs20: coin_val = CREDIT_W'(4);
      default:  coin_val = '0;
    endcase
  end

  assign coin_nonzero = coin_valid && (coin != 2'b00);

  // The sum is one bit wider than credit so the cap compare can never see a wrapped value.
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits  = (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Look up the price by scanning the table. Any index with no matching entry, which can
  // happen when NUM_PROD is not a power of two, is flagged as out of range.
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in_range;
  logic                sel_ok;
  logic [CREDIT_W-1:0] sel_remainder;

  always_comb begin
    sel_price    = '0;
    sel_in_range = 1'b0;
    for (int unsigned i = 0; i < NUM_PROD; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_price    = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_in_range = 1'b1;
      end
    end
  end

  assign sel_ok        = sel_in_range && (sel_price <= credit_q);
  assign sel_remainder = credit_q - sel_price;

  // Change denomination for this cycle: Rs10 while at least two units remain, else Rs5.
  logic                change_big;
  logic [CREDIT_W-1:0] change_left;

  assign change_big  = (credit_q >= CREDIT_W'(2));
  assign change_left = change_big ? (credit_q - CREDIT_W'(2))
                                  : (credit_q - CREDIT_W'(1));

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q             <= StIdle;
      credit_q            <= '0;
      product_id_q        <= '0;
      change_coin_q       <= 2'b00;
      coin_accept_q       <= 1'b0;
      coin_reject_q       <= 1'b0;
      product_dispensed_q <= 1'b0;
      sel_error_q         <= 1'b0;
      change_valid_q      <= 1'b0;
    end else begin
      state_q             <= state_d;
      credit_q            <= credit_d;
      product_id_q        <= product_id_d;
      change_coin_q       <= change_coin_d;
      coin_accept_q       <= coin_accept_d;
      coin_reject_q       <= coin_reject_d;
      product_dispensed_q <= product_dispensed_d;
      sel_error_q         <= sel_error_d;
      change_valid_q      <= change_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and credit
  // ---------------------------------------------------------------------------

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    case (state_q)
      StIdle, StCredit: begin
        // Priority: cancel, then selection, then coin.
        if (cancel) begin
          if (credit_q != '0) begin
            state_d = StChange;
          end
        end else if (sel_valid) begin
          if (sel_ok) begin
            credit_d = sel_remainder;
            state_d  = (sel_remainder != '0) ? StChange : StIdle;
          end
        end else if (coin_nonzero && coin_fits) begin
          credit_d = credit_sum[CREDIT_W-1:0];
          state_d  = StCredit;
        end
      end
      StChange: begin
        if (credit_q == '0) begin
          // Never entered with zero credit; recover anyway.
          state_d = StIdle;
        end else begin
          credit_d = change_left;
          state_d  = (change_left == '0) ? StIdle : StChange;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next values of the registered outputs
  // ---------------------------------------------------------------------------

  always_comb begin
    coin_accept_d       = 1'b0;
    coin_reject_d       = 1'b0;
    product_dispensed_d = 1'b0;
    sel_error_d         = 1'b0;
    change_valid_d      = 1'b0;
    change_coin_d       = 2'b00;
    product_id_d        = product_id_q;
    case (state_q)
      StIdle, StCredit: begin
        if (cancel || sel_valid) begin
          // A coin that loses to cancel or select goes straight back to the customer.
          coin_reject_d = coin_nonzero;
          if (!cancel) begin
            if (sel_ok) begin
              product_dispensed_d = 1'b1;
              product_id_d        = sel_id;
            end else begin
              sel_error_d = 1'b1;
            end
          end
        end else if (coin_nonzero) begin
          coin_accept_d = coin_fits;
          coin_reject_d = !coin_fits;
        end
      end
      StChange: begin
        // Selection and cancel are ignored here; every valid coin is bounced.
        coin_reject_d = coin_nonzero;
        if (credit_q != '0) begin
          change_valid_d = 1'b1;
          change_coin_d  = change_big ? CoinRs10 : CoinRs5;
        end
      end
      default: begin
        coin_reject_d = coin_nonzero;
      end
    endcase
  end

  assign coin_accept       = coin_accept_q;
  assign coin_reject       = coin_reject_q;
  assign product_dispensed = product_dispensed_q;
  assign product_id        = product_id_q;
  assign sel_error         = sel_error_q;
  assign change_valid      = change_valid_q;
  assign change_coin       = change_coin_q;
  assign credit            = credit_q;
  assign busy              = (state_q == StChange);

endmodule

// File: tb/tb_vending_controller_param.sv
module tb_vending_controller_param;

  localparam int unsigned CW   = 6;
  localparam int unsigned NP   = 5;
  localparam int unsigned IDW  = 3;
  localparam int unsigned MAXC = 8;
  localparam logic [NP*CW-1:0] PR = {6'd7, 6'd4, 6'd3, 6'd2, 6'd1};

  int prices [NP] = '{1, 2, 3, 4, 7};

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           coin_valid = 1'b0;
  logic [1:0]     coin = 2'b00;
  logic           sel_valid = 1'b0;
  logic [IDW-1:0] sel_id = '0;
  logic           cancel = 1'b0;
  logic           coin_accept, coin_reject, product_dispensed, sel_error, change_valid, busy;
  logic [IDW-1:0] product_id;
  logic [1:0]     change_coin;
  logic [CW-1:0]  credit;

  vending_controller_param #(
    .CREDIT_W  (CW),
    .NUM_PROD  (NP),
    .PRICES    (PR),
    .MAX_CREDIT(MAXC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .coin_valid       (coin_valid),
    .coin             (coin),
    .sel_valid        (sel_valid),
    .sel_id           (sel_id),
    .cancel           (cancel),
    .coin_accept      (coin_accept),
    .coin_reject      (coin_reject),
    .product_dispensed(product_dispensed),
    .product_id       (product_id),
    .sel_error        (sel_error),
    .change_valid     (change_valid),
    .change_coin      (change_coin),
    .credit           (credit),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: integer credit plus a "refunding" flag, and the expected outputs.
  int             r_credit;
  bit             r_refund;
  bit             e_acc, e_rej, e_disp, e_err, e_cv;
  logic [IDW-1:0] e_pid;
  logic [1:0]     e_cc;

  function automatic logic [16:0] dut_vec();
    return {coin_accept, coin_reject, product_dispensed, product_id, sel_error,
            change_valid, change_coin, credit, busy};
  endfunction

  function automatic logic [16:0] exp_vec();
    return {e_acc, e_rej, e_disp, e_pid, e_err, e_cv, e_cc, CW'(r_credit), r_refund};
  endfunction

  task automatic model_reset();
    r_credit = 0; r_refund = 0;
    e_acc = 0; e_rej = 0; e_disp = 0; e_err = 0; e_cv = 0; e_pid = '0; e_cc = 2'b00;
  endtask

  // Apply one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic step(input bit cv, input logic [1:0] c, input bit sv,
                      input logic [IDW-1:0] sid, input bit cn);
    bit nz;
    int val;
    coin_valid = cv; coin = c; sel_valid = sv; sel_id = sid; cancel = cn;
    nz  = cv && (c != 2'b00);
    val = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 4 : 0;
    e_acc = 0; e_rej = 0; e_disp = 0; e_err = 0; e_cv = 0; e_cc = 2'b00;
    if (r_refund) begin
      e_rej = nz;
      e_cv  = 1;
      if (r_credit >= 2) begin e_cc = 2'b10; r_credit -= 2; end
      else begin e_cc = 2'b01; r_credit -= 1; end
      if (r_credit == 0) r_refund = 0;
    end else if (cn) begin
      e_rej = nz;
      if (r_credit > 0) r_refund = 1;
    end else if (sv) begin
      e_rej = nz;
      if (int'(sid) < NP && prices[sid] <= r_credit) begin
        e_disp = 1; e_pid = sid;
        r_credit -= prices[sid];
        r_refund = (r_credit > 0);
      end else begin
        e_err = 1;
      end
    end else if (nz) begin
      if (r_credit + val <= MAXC) begin e_acc = 1; r_credit += val; end
      else e_rej = 1;
    end
    @(posedge clk);
    #1;
    coin_valid = 0; sel_valid = 0; cancel = 0; coin = 2'b00;
  endtask

  task automatic test_reset();
    int ncv;
    rst = 0;
    #2;
    n_checks++;
    if (dut_vec() !== 17'd0) begin
      n_fail++; $display("FAIL reset_initial: got %h want 0", dut_vec());
    end
    model_reset();
    @(negedge clk); rst = 1;
    step(1, 2'b11, 0, 0, 0);
    step(0, 2'b00, 1, 0, 0);
    n_checks++;
    if ({busy, credit} !== {1'b1, 6'd3}) begin
      n_fail++; $display("FAIL reset_setup: got busy/credit %b/%0d want 1/3", busy, credit);
    end
    #3 rst = 0;
    #1;
    n_checks++;
    if (dut_vec() !== 17'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", dut_vec());
    end
    model_reset();
    @(negedge clk); rst = 1;
    ncv = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 2'b00, 0, 0, 0);
      if (change_valid) ncv++;
    end
    n_checks++;
    if (ncv != 0 || credit !== 6'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_change: got cv=%0d credit=%0d busy=%b want 0/0/0",
                         ncv, credit, busy);
    end
  endtask

  task automatic test_exact_vend();
    int ncv;
    step(1, 2'b01, 0, 0, 0);
    n_checks++;
    if ({coin_accept, credit} !== {1'b1, 6'd1}) begin
      n_fail++; $display("FAIL exact_coin1: got acc/credit %b/%0d want 1/1", coin_accept, credit);
    end
    step(1, 2'b10, 0, 0, 0);
    n_checks++;
    if ({coin_accept, credit} !== {1'b1, 6'd3}) begin
      n_fail++; $display("FAIL exact_coin2: got acc/credit %b/%0d want 1/3", coin_accept, credit);
    end
    step(0, 2'b00, 1, 2, 0);
    n_checks++;
    if ({product_dispensed, product_id, credit, busy} !== {1'b1, 3'd2, 6'd0, 1'b0}) begin
      n_fail++; $display("FAIL exact_vend: got disp/id/credit/busy %b/%0d/%0d/%b want 1/2/0/0",
                         product_dispensed, product_id, credit, busy);
    end
    ncv = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 0, 0, 0);
      if (change_valid || busy) ncv++;
    end
    n_checks++;
    if (ncv != 0) begin
      n_fail++; $display("FAIL exact_no_change: got %0d active cycles want 0", ncv);
    end
  endtask

  task automatic test_change_return();
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b11, 0, 0, 0);
    n_checks++;
    if (credit !== 6'd8) begin
      n_fail++; $display("FAIL change_credit8: got %0d want 8", credit);
    end
    step(0, 2'b00, 1, 1, 0);
    n_checks++;
    if ({product_dispensed, product_id, credit, busy, change_valid} !==
        {1'b1, 3'd1, 6'd6, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL change_vend: got %h want disp id1 credit6 busy", dut_vec());
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 0, 0, 0);
      n_checks++;
      if ({change_valid, change_coin, credit, busy} !==
          {1'b1, 2'b10, CW'(4 - 2 * i), (i < 2)}) begin
        n_fail++; $display("FAIL change_coin%0d: got cv/cc/credit/busy %b/%b/%0d/%b want 1/10/%0d/%b",
                           i, change_valid, change_coin, credit, busy, 4 - 2 * i, i < 2);
      end
    end
    step(0, 2'b00, 0, 0, 0);
    n_checks++;
    if ({change_valid, change_coin} !== 3'b000) begin
      n_fail++; $display("FAIL change_done: got cv/cc %b/%b want 0/00", change_valid, change_coin);
    end
  endtask

  task automatic test_overflow_reject();
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    n_checks++;
    if ({coin_accept, coin_reject, credit} !== {1'b0, 1'b1, 6'd7}) begin
      n_fail++; $display("FAIL overflow_reject: got acc/rej/credit %b/%b/%0d want 0/1/7",
                         coin_accept, coin_reject, credit);
    end
    step(0, 2'b00, 1, 3, 0);
    n_checks++;
    if ({product_dispensed, product_id, credit, busy} !== {1'b1, 3'd3, 6'd3, 1'b1}) begin
      n_fail++; $display("FAIL overflow_vend: got %h want disp id3 credit3 busy", dut_vec());
    end
    step(0, 2'b00, 0, 0, 0);
    n_checks++;
    if ({change_valid, change_coin, credit} !== {1'b1, 2'b10, 6'd1}) begin
      n_fail++; $display("FAIL overflow_chg1: got cv/cc/credit %b/%b/%0d want 1/10/1",
                         change_valid, change_coin, credit);
    end
    step(0, 2'b00, 0, 0, 0);
    n_checks++;
    if ({change_valid, change_coin, credit, busy} !== {1'b1, 2'b01, 6'd0, 1'b0}) begin
      n_fail++; $display("FAIL overflow_chg2: got cv/cc/credit/busy %b/%b/%0d/%b want 1/01/0/0",
                         change_valid, change_coin, credit, busy);
    end
  endtask

  task automatic test_sel_error();
    step(1, 2'b01, 0, 0, 0);
    step(0, 2'b00, 1, 3, 0);
    n_checks++;
    if ({sel_error, product_dispensed, credit, busy} !== {1'b1, 1'b0, 6'd1, 1'b0}) begin
      n_fail++; $display("FAIL selerr_price: got err/disp/credit/busy %b/%b/%0d/%b want 1/0/1/0",
                         sel_error, product_dispensed, credit, busy);
    end
    step(0, 2'b00, 1, 6, 0);
    n_checks++;
    if ({sel_error, product_dispensed, credit} !== {1'b1, 1'b0, 6'd1}) begin
      n_fail++; $display("FAIL selerr_range: got err/disp/credit %b/%b/%0d want 1/0/1",
                         sel_error, product_dispensed, credit);
    end
    step(1, 2'b01, 1, 0, 0);
    n_checks++;
    if ({product_dispensed, product_id, coin_reject, coin_accept, credit, busy} !==
        {1'b1, 3'd0, 1'b1, 1'b0, 6'd0, 1'b0}) begin
      n_fail++; $display("FAIL selerr_vend_coin: got %h want disp id0 reject credit0", dut_vec());
    end
  endtask

  task automatic test_cancel();
    step(0, 2'b00, 0, 0, 1);
    n_checks++;
    if ({busy, credit, change_valid} !== {1'b0, 6'd0, 1'b0}) begin
      n_fail++; $display("FAIL cancel_empty: got busy/credit %b/%0d want 0/0", busy, credit);
    end
    step(1, 2'b11, 0, 0, 0);
    step(1, 2'b01, 0, 0, 0);
    step(0, 2'b00, 1, 0, 1);
    n_checks++;
    if ({product_dispensed, sel_error, busy, credit} !== {1'b0, 1'b0, 1'b1, 6'd5}) begin
      n_fail++; $display("FAIL cancel_start: got disp/err/busy/credit %b/%b/%b/%0d want 0/0/1/5",
                         product_dispensed, sel_error, busy, credit);
    end
    step(1, 2'b10, 0, 0, 0);
    n_checks++;
    if ({change_valid, change_coin, credit, coin_reject, coin_accept} !==
        {1'b1, 2'b10, 6'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL cancel_chg1: got %h want rs10 credit3 reject", dut_vec());
    end
    step(0, 2'b00, 1, 0, 1);
    n_checks++;
    if ({change_valid, change_coin, credit, sel_error, product_dispensed} !==
        {1'b1, 2'b10, 6'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL cancel_chg2: got %h want rs10 credit1", dut_vec());
    end
    step(0, 2'b00, 0, 0, 0);
    n_checks++;
    if ({change_valid, change_coin, credit, busy} !== {1'b1, 2'b01, 6'd0, 1'b0}) begin
      n_fail++; $display("FAIL cancel_chg3: got cv/cc/credit/busy %b/%b/%0d/%b want 1/01/0/0",
                         change_valid, change_coin, credit, busy);
    end
  endtask

  task automatic test_random();
    bit             cv, sv, cn;
    logic [1:0]     c;
    logic [IDW-1:0] sid;
    for (int i = 0; i < 600; i++) begin
      cv  = ($urandom_range(0, 9) < 5);
      c   = 2'($urandom_range(0, 3));
      sv  = ($urandom_range(0, 9) < 2);
      sid = IDW'($urandom_range(0, 7));
      cn  = ($urandom_range(0, 24) == 0);
      step(cv, c, sv, sid, cn);
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_exact_vend();
    test_change_return();
    test_overflow_reject();
    test_sel_error();
    test_cancel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vending_controller_param.md
# vending_controller_param

Parametrised vending controller: the next generation of the team's three-product, fixed-price vending FSM. It supports:
- a configurable number of products with a per-product price table;
- a credit accumulator with a saturation guard and coin rejection;
- explicit selection and cancel inputs;
- serial change return, one coin per cycle, largest coin first.

It sits between the coin-acceptor front end and the dispenser/change-hopper drivers. All outputs are registered.

## Interface
Parameters (all prices and credit are in units of Rs 5):
- CREDIT_W, 6: width of the credit register and of each price entry.
- NUM_PROD, 4: number of products; must be ≥ 2.
- PRICES, {6'd4,6'd3,6'd2,6'd1}: packed NUM_PROD*CREDIT_W vector. Entry i is at bits [i*CREDIT_W +: CREDIT_W]. Default prices are p0=Rs5, p1=Rs10, p2=Rs15, p3=Rs20.
- MAX_CREDIT, 8: largest credit held (Rs 40); must be < 2^CREDIT_W.

Ports (ID_W = $clog2(NUM_PROD)):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin strobe.
- coin  in  2  coin code: 01 = Rs5 (1 unit), 10 = Rs10 (2 units), 11 = Rs20 (4 units), 00 = invalid.
- sel_valid  in  1  one-cycle product request.
- sel_id  in  ID_W  requested product index.
- cancel  in  1  refund request.
- coin_accept  out  1  pulse: coin added to credit.
- coin_reject  out  1  pulse: coin returned to the customer.
- product_dispensed  out  1  pulse: product released.
- product_id  out  ID_W  index of the dispensed product; holds its value between vends.
- sel_error  out  1  pulse: selection invalid or credit insufficient.
- change_valid  out  1  pulse: one change coin is output.
- change_coin  out  2  01 = Rs5, 10 = Rs10; 00 when change_valid = 0.
- credit  out  CREDIT_W  current credit register.
- busy  out  1  high while change is being returned.

## Operation
States:
- IDLE: credit = 0.
- CREDIT: credit > 0.
- CHANGE: returning credit.

Input priority in IDLE/CREDIT within one cycle: cancel > sel_valid > coin_valid. Only the winning input acts. Any losing coin_valid with a nonzero code gets coin_reject.

Coin handling:
- Coin code 00 is ignored, with no pulse.
- Valid coin with credit+value ≤ MAX_CREDIT: credit += value, coin_accept pulses, state goes to CREDIT.
- Valid coin with credit+value > MAX_CREDIT: coin_reject pulses, credit unchanged.

Selection handling:
- sel_id ≥ NUM_PROD, or PRICES[sel_id] > credit: sel_error pulses; state and credit are unchanged.
- Otherwise: product_dispensed pulses, product_id = sel_id, credit -= price. The next state is CHANGE if the remainder > 0, else IDLE.

Cancel handling:
- With credit > 0: go to CHANGE, returning the full credit.
- With credit = 0: no effect.

CHANGE state:
- One coin is emitted per cycle: Rs10 (credit -= 2) while credit ≥ 2, else Rs5 (credit -= 1).
- The coin that brings credit to 0 moves the state to IDLE.
- In CHANGE, every valid coin gets coin_reject. sel_valid and cancel are ignored, with no sel_error.

Arithmetic:
- Unsigned, CREDIT_W bits.
- The sum is computed CREDIT_W+1 wide for the MAX_CREDIT compare, so credit never wraps.

## Timing
- Reset (rst = 0, asynchronous) forces:
  - state IDLE;
  - credit 0, product_id 0, change_coin 00;
  - all pulse outputs 0, busy 0.
- Deassertion takes effect at the first clk edge with rst = 1.
- Reset mid-CHANGE drops the outstanding change; this is intended, since the hopper is reset too.
- All input strobes are sampled at edge k; the responses (coin_accept/coin_reject/sel_error/product_dispensed and the credit update) are visible in cycle k+1.
- A vend accepted at edge k:
  - product_dispensed is high in cycle k+1;
  - busy = 1 in cycle k+1 if change is due;
  - the first change_valid is in cycle k+2;
  - change coins follow in consecutive cycles.
- busy = (state == CHANGE). It drops in the same cycle as the final change_valid.
- A new coin or selection can be accepted at the first edge where busy is sampled low.
- Pulses last exactly one cycle. Back-to-back coins are accepted on consecutive cycles.

## Test plan
- Reset: assert rst = 0 mid-CHANGE with credit 3 -> outputs go to reset values immediately; no further change_valid after release.
- Coins Rs5, Rs10 on consecutive cycles, then select id 2 (Rs15) -> coin_accept ×2, credit 1 then 3, product_dispensed with product_id 2, credit 0, no change_valid, busy stays 0.
- Rs20 + Rs20 (credit 8), then select id 1 (Rs10) -> product_dispensed, then change_valid ×3: Rs10, Rs10, Rs10. busy is high 3 cycles; credit steps 6, 4, 2, 0.
- Credit 7, insert Rs10 -> coin_reject, credit stays 7. Then select id 3 (price 4) -> dispense, remainder 3 returned as Rs10 then Rs5.
- Credit 1, select id 3 -> sel_error, credit 1. Select id 0 with simultaneous coin Rs5 -> dispense id 0, coin_reject.
- Credit 5, assert cancel with sel_valid in the same cycle -> no dispense; change Rs10, Rs10, Rs5. A coin inserted while busy -> coin_reject.
